// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among NREQ
//            requesters. Optional busy-rise timeout: UART_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int TMO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        din,
    output logic              wr_en,
    input  logic              tx_busy
);

    localparam int c_PW = $clog2(NREQ);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TMO_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NREQ must be 2..8 and TMO_CYCLES >= 1");
    end

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_ack;
    logic [7:0]      r_din;
    logic            r_wr_en;
    logic [c_PW-1:0] r_rr_ptr;
    logic [c_PW-1:0] r_owner;

    logic            w_found;
    logic [c_PW-1:0] w_cand;
    logic [c_PW-1:0] w_sel_idx;
    logic [7:0]      w_sel_data;
    logic [NREQ-1:0] w_sel_onehot;
    logic [c_PW-1:0] w_next_rr;
    logic            w_done_pulse;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int              c_TW       = $clog2(TMO_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TMO_CYCLES - 1);

    logic [NREQ-1:0] r_err;
    logic [c_TW-1:0] r_tmo_cnt;

    assign err          = r_err;
    assign w_done_pulse = (|r_ack) | (|r_err);
`else
    assign err          = '0;
    assign w_done_pulse = |r_ack;
`endif

    assign grant = r_grant;
    assign ack   = r_ack;
    assign din   = r_din;
    assign wr_en = r_wr_en;

    // First requester at or after rr_ptr, searching with wrap-around.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = c_PW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_data   = '0;
        w_sel_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel_idx == c_PW'(i)) begin
                w_sel_data      = req_data[8*i +: 8];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_next_rr = (r_owner == c_PW'(NREQ - 1)) ? '0 : r_owner + c_PW'(1);

    // No grant on the ack/err cycle: the finishing requester has not yet had
    // a chance to drop its request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_grant  <= '0;
            r_ack    <= '0;
            r_din    <= 8'h00;
            r_wr_en  <= 1'b0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_err     <= '0;
            r_tmo_cnt <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            r_ack   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_err   <= '0;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    if (!tx_busy && w_found && !w_done_pulse) begin
                        r_din   <= w_sel_data;
                        r_grant <= w_sel_onehot;
                        r_owner <= w_sel_idx;
                        r_wr_en <= 1'b1;
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state <= c_ST_WAIT_BUSY;
                end
                c_ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= c_ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_err    <= r_grant;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_rr;
                        r_state  <= c_ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
`endif
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_ack    <= r_grant;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_rr;
                        r_state  <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
